// File: rtl/sequence_stream_controller_if.sv
// Handshake/data bundle between host, sequence_stream_controller and the sequence detector.
// master = host + detector side, slave = controller.
interface sequence_stream_controller_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned LEN_W = 5
);
  logic             Start;
  logic             Abort;
  logic             StepEn;
  logic [WIDTH-1:0] Pattern;
  logic [LEN_W-1:0] Len;
  logic             DetZ;
  logic             DetW;
  logic             DetEn;
  logic             DetResetn;
  logic             Busy;
  logic             Done;
  logic [1:0]       State;
  logic [CNT_W-1:0] MatchCount;
  logic [LEN_W-1:0] FirstMatchIdx;

  modport master (
    output Start, Abort, StepEn, Pattern, Len, DetZ,
    input  DetW, DetEn, DetResetn, Busy, Done, State, MatchCount, FirstMatchIdx
  );

  modport slave (
    input  Start, Abort, StepEn, Pattern, Len, DetZ,
    output DetW, DetEn, DetResetn, Busy, Done, State, MatchCount, FirstMatchIdx
  );
endinterface

// File: rtl/sequence_stream_controller.sv
// Streams a latched pattern MSB-first into a single-bit sequence detector and counts z matches.
// Optional first-match index logging is enabled by defining MATCH_LOG_EN.
module sequence_stream_controller #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned LEN_W = 5
) (
  input logic                         Clock,
  input logic                         Reset,
  sequence_stream_controller_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StClear = 2'b01;
  localparam logic [1:0] StRun   = 2'b10;
  localparam logic [1:0] StDone  = 2'b11;

  localparam logic [LEN_W-1:0] WidthLen = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic [LEN_W-1:0] len_eff;
  logic             det_en;
  logic             count_hit;

  assign len_eff   = (bus.Len > WidthLen) ? WidthLen : bus.Len;
  assign det_en    = (state_q == StRun) & bus.StepEn & (remaining_q != '0) & ~bus.Abort;
  // pending_q marks that DetZ now reflects the bit consumed on the previous edge.
  assign count_hit = (state_q == StRun) & pending_q & bus.DetZ & ~bus.Abort;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    match_cnt_d = match_cnt_q;
    if (bus.Abort) begin
      state_d   = StIdle;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.Start) begin
            shift_d     = bus.Pattern;
            remaining_d = len_eff;
            pending_d   = 1'b0;
            match_cnt_d = '0;
            state_d     = StClear;
          end
        end
        StClear: state_d = StRun;
        StRun: begin
          if (det_en) begin
            shift_d     = {shift_q[WIDTH-2:0], 1'b0};
            remaining_d = remaining_q - 1'b1;
            pending_d   = 1'b1;
          end else begin
            pending_d   = 1'b0;
          end
          if (count_hit && (match_cnt_q != CntMax)) begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
          if ((remaining_q == '0) && !pending_q) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      match_cnt_q <= match_cnt_d;
    end
  end

`ifdef MATCH_LOG_EN
  logic [LEN_W-1:0] consumed_q, consumed_d;
  logic [LEN_W-1:0] first_idx_q, first_idx_d;

  // consumed_q already includes the bit whose z is being sampled, so it is that bit's 1-based index.
  always_comb begin
    consumed_d  = consumed_q;
    first_idx_d = first_idx_q;
    if (!bus.Abort) begin
      if ((state_q == StIdle) && bus.Start) begin
        consumed_d  = '0;
        first_idx_d = '0;
      end else if (state_q == StRun) begin
        if (det_en) begin
          consumed_d = consumed_q + 1'b1;
        end
        if (count_hit && (first_idx_q == '0)) begin
          first_idx_d = consumed_q;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      consumed_q  <= '0;
      first_idx_q <= '0;
    end else begin
      consumed_q  <= consumed_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign bus.FirstMatchIdx = first_idx_q;
`else
  assign bus.FirstMatchIdx = '0;
`endif

  assign bus.DetW       = shift_q[WIDTH-1];
  assign bus.DetEn      = det_en;
  assign bus.DetResetn  = (state_q != StClear);
  assign bus.Busy       = (state_q == StClear) | (state_q == StRun);
  assign bus.Done       = (state_q == StDone);
  assign bus.State      = state_q;
  assign bus.MatchCount = match_cnt_q;

endmodule

// File: tb/tb_sequence_stream_controller.sv
// Directed bench for sequence_stream_controller with a reference four-equal-bits detector.
module tb_sequence_stream_controller;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

`ifdef MATCH_LOG_EN
  localparam int unsigned IdxOn = 1;
`else
  localparam int unsigned IdxOn = 0;
`endif

  sequence_stream_controller_if #(.WIDTH(16), .CNT_W(5), .LEN_W(5)) bus ();
  sequence_stream_controller_if #(.WIDTH(16), .CNT_W(3), .LEN_W(5)) bus3 ();

  sequence_stream_controller #(.WIDTH(16), .CNT_W(5), .LEN_W(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  sequence_stream_controller #(.WIDTH(16), .CNT_W(3), .LEN_W(5)) dut3 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus3)
  );

  // Reference detector: z=1 once four equal consecutive bits have been seen (overlapping).
  function automatic logic [2:0] next_run(input logic [2:0] r, input logic w, input logic last);
    if ((r != 3'd0) && (w == last)) return (r >= 3'd4) ? 3'd4 : r + 3'd1;
    return 3'd1;
  endfunction

  logic [2:0] run_a = '0, run_b = '0;
  logic       last_a = 1'b0, last_b = 1'b0;
  logic       z_a = 1'b0, z_b = 1'b0;

  always @(posedge Clock) begin
    if (Reset || !bus.DetResetn) begin
      run_a <= '0; last_a <= 1'b0; z_a <= 1'b0;
    end else if (bus.DetEn) begin
      run_a  <= next_run(run_a, bus.DetW, last_a);
      last_a <= bus.DetW;
      z_a    <= (next_run(run_a, bus.DetW, last_a) == 3'd4);
    end
    if (Reset || !bus3.DetResetn) begin
      run_b <= '0; last_b <= 1'b0; z_b <= 1'b0;
    end else if (bus3.DetEn) begin
      run_b  <= next_run(run_b, bus3.DetW, last_b);
      last_b <= bus3.DetW;
      z_b    <= (next_run(run_b, bus3.DetW, last_b) == 3'd4);
    end
  end

  assign bus.DetZ  = z_a;
  assign bus3.DetZ = z_b;

  int en_cnt = 0, clr_cnt = 0, done_cnt = 0, en3_cnt = 0;
  always @(posedge Clock) begin
    if (bus.DetEn)      en_cnt   <= en_cnt + 1;
    if (!bus.DetResetn) clr_cnt  <= clr_cnt + 1;
    if (bus.Done)       done_cnt <= done_cnt + 1;
    if (bus3.DetEn)     en3_cnt  <= en3_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] pat, input logic [4:0] len);
    bus.Pattern = pat;
    bus.Len     = len;
    bus.Start   = 1'b1;
    tick();
    bus.Start   = 1'b0;
  endtask

  // Ticks counts from the Start edge (that edge is tick 1).
  task automatic wait_done(input int limit, input bit toggle, output int ticks);
    ticks = 1;
    while (!bus.Done && ticks < limit) begin
      if (toggle) bus.StepEn = ~bus.StepEn;
      tick();
      ticks++;
    end
  endtask

  int t, e0;

  initial begin
    bus.Start = 0; bus.Abort = 0; bus.StepEn = 0; bus.Pattern = '0; bus.Len = '0;
    bus3.Start = 0; bus3.Abort = 0; bus3.StepEn = 0; bus3.Pattern = '0; bus3.Len = '0;
    tick();
    tick();
    check("rst_state", bus.State, 2'b00);
    check("rst_detw", bus.DetW, 1'b0);
    check("rst_deten", bus.DetEn, 1'b0);
    check("rst_detresetn", bus.DetResetn, 1'b1);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_count", bus.MatchCount, 5'd0);
    check("rst_idx", bus.FirstMatchIdx, 5'd0);
    Reset = 1'b0;
    tick();

    // Run 1: 0F00, 16 bits, StepEn held high.
    bus.StepEn = 1'b1;
    e0 = en_cnt;
    launch(16'h0F00, 5'd16);
    check("t1_state_clear", bus.State, 2'b01);
    check("t1_detresetn_low", bus.DetResetn, 1'b0);
    check("t1_busy", bus.Busy, 1'b1);
    wait_done(60, 1'b0, t);
    check("t1_done_seen", bus.Done, 1'b1);
    check("t1_done_tick", t, 20);
    check("t1_count", bus.MatchCount, 5'd7);
    check("t1_idx", bus.FirstMatchIdx, IdxOn ? 5'd4 : 5'd0);
    check("t1_en_cycles", en_cnt - e0, 16);
    tick();
    check("t1_idle_after", bus.State, 2'b00);
    check("t1_done_pulse", bus.Done, 1'b0);
    check("t1_count_hold", bus.MatchCount, 5'd7);

    // Run 2: same pattern, StepEn toggling.
    e0 = en_cnt;
    launch(16'h0F00, 5'd16);
    wait_done(120, 1'b1, t);
    check("t2_done_seen", bus.Done, 1'b1);
    check("t2_count", bus.MatchCount, 5'd7);
    check("t2_en_cycles", en_cnt - e0, 16);
    bus.StepEn = 1'b1;
    tick();

    // Run 3: Len above WIDTH clamps to 16.
    e0 = en_cnt;
    launch(16'hFFFF, 5'd31);
    wait_done(60, 1'b0, t);
    check("t3_done_tick", t, 20);
    check("t3_count", bus.MatchCount, 5'd13);
    check("t3_en_cycles", en_cnt - e0, 16);
    check("t3_idx", bus.FirstMatchIdx, IdxOn ? 5'd4 : 5'd0);
    tick();

    // Run 4: Len=0.
    e0 = en_cnt;
    launch(16'hFFFF, 5'd0);
    check("t4_state1", bus.State, 2'b01);
    tick();
    check("t4_state2", bus.State, 2'b10);
    tick();
    check("t4_state3", bus.State, 2'b11);
    check("t4_done", bus.Done, 1'b1);
    check("t4_count", bus.MatchCount, 5'd0);
    tick();
    check("t4_state0", bus.State, 2'b00);
    check("t4_en_none", en_cnt - e0, 0);

    // Run 5: Start ignored mid-run, then Abort after 6 bits of zeros.
    e0 = en_cnt;
    launch(16'h0000, 5'd16);
    tick();
    repeat (4) tick();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("t5_start_ignored_state", bus.State, 2'b10);
    check("t5_count_bit4", bus.MatchCount, 5'd1);
    tick();
    bus.StepEn = 1'b0;
    tick();
    check("t5_count_partial", bus.MatchCount, 5'd3);
    check("t5_en_cycles", en_cnt - e0, 6);
    bus.StepEn = 1'b1;
    bus.Abort  = 1'b1;
    #1;
    check("t5_abort_deten", bus.DetEn, 1'b0);
    tick();
    bus.Abort = 1'b0;
    check("t5_abort_idle", bus.State, 2'b00);
    check("t5_abort_nodone", bus.Done, 1'b0);
    check("t5_abort_count", bus.MatchCount, 5'd3);
    tick();
    check("t5_still_idle", bus.State, 2'b00);

    // Run 6: Reset mid-run.
    launch(16'h0F00, 5'd16);
    tick();
    repeat (10) tick();
    check("t6_count_mid", bus.MatchCount, 5'd2);
    Reset = 1'b1;
    tick();
    check("t6_state", bus.State, 2'b00);
    check("t6_detresetn", bus.DetResetn, 1'b1);
    check("t6_count", bus.MatchCount, 5'd0);
    check("t6_deten", bus.DetEn, 1'b0);
    Reset = 1'b0;
    tick();
    check("clear_per_start", clr_cnt, 6);
    check("done_pulses", done_cnt, 4);

    // CNT_W=3 instance: 13 raw matches saturate at 7.
    e0 = en3_cnt;
    bus3.StepEn  = 1'b1;
    bus3.Pattern = 16'hFFFF;
    bus3.Len     = 5'd16;
    bus3.Start   = 1'b1;
    tick();
    bus3.Start = 1'b0;
    t = 1;
    while (!bus3.Done && t < 60) begin
      tick();
      t++;
    end
    check("sat_done_seen", bus3.Done, 1'b1);
    check("sat_count", bus3.MatchCount, 3'd7);
    check("sat_en_cycles", en3_cnt - e0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
